// File: rtl/adder_arbiter_pkg.sv
// Shared encodings for the adder arbiter: op modes, saturation limits, requester indices.
package adder_arbiter_pkg;
  localparam logic        MODE_ADD = 1'b0;
  localparam logic        MODE_SUB = 1'b1;
  localparam logic [15:0] SAT_POS  = 16'h7FFF;
  localparam logic [15:0] SAT_NEG  = 16'h8000;
  localparam logic        SRC_EX   = 1'b0;
  localparam logic        SRC_AUX  = 1'b1;
endpackage

// File: rtl/sat_addsub.sv
// Combinational saturating add/subtract with N/Z/V flags; zero latency, no handshake.
module sat_addsub
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             n,
  output logic             z,
  output logic             v
);
  localparam logic [WIDTH-1:0] LP_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LP_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_cin;
  logic [WIDTH-1:0] w_raw;

  // Subtraction as A + ~B + 1 so one adder and one overflow rule cover both ops.
  assign w_bop = (mode == MODE_SUB) ? ~b : b;
  assign w_cin = {{(WIDTH-1){1'b0}}, (mode == MODE_SUB)};
  assign w_raw = a + w_bop + w_cin;

  assign v   = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
  assign sum = v ? (a[WIDTH-1] ? LP_NEG : LP_POS) : w_raw;
  assign n   = sum[WIDTH-1];
  assign z   = (sum == '0);
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin share of one saturating add/sub between two requesters; result registered, 1-cycle latency.
// Grants only while the output register is empty or draining, so out_ready=0 stalls both requesters.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAGW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             mode0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [TAGW-1:0]  tag0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             mode1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [TAGW-1:0]  tag1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [TAGW-1:0]  out_tag,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_n,
  output logic             out_z,
  output logic             out_v
);
  logic             r_ptr;
  logic             r_valid;
  logic             r_src;
  logic [TAGW-1:0]  r_tag;
  logic [WIDTH-1:0] r_sum;
  logic             r_n;
  logic             r_z;
  logic             r_v;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt;
  logic             w_src;
  logic             w_mode;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [TAGW-1:0]  w_tag;
  logic [WIDTH-1:0] w_sum;
  logic             w_n;
  logic             w_z;
  logic             w_v;

  assign w_can_accept = !r_valid || out_ready;

  // Pointer only matters under contention; a lone requester always wins.
  assign w_gnt0 = rst_n && w_can_accept && req0 && (!req1 || (r_ptr == SRC_EX));
  assign w_gnt1 = rst_n && w_can_accept && req1 && (!req0 || (r_ptr == SRC_AUX));
  assign w_gnt  = w_gnt0 || w_gnt1;
  assign w_src  = w_gnt1 ? SRC_AUX : SRC_EX;

  assign w_mode = w_gnt1 ? mode1 : mode0;
  assign w_a    = w_gnt1 ? a1    : a0;
  assign w_b    = w_gnt1 ? b1    : b0;
  assign w_tag  = w_gnt1 ? tag1  : tag0;

  sat_addsub #(.WIDTH(WIDTH)) u_sat_addsub (
    .mode (w_mode),
    .a    (w_a),
    .b    (w_b),
    .sum  (w_sum),
    .n    (w_n),
    .z    (w_z),
    .v    (w_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= SRC_EX;
      r_valid <= 1'b0;
      r_src   <= 1'b0;
      r_tag   <= '0;
      r_sum   <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
    end else if (w_gnt) begin
      r_ptr   <= ~w_src;
      r_valid <= 1'b1;
      r_src   <= w_src;
      r_tag   <= w_tag;
      r_sum   <= w_sum;
      r_n     <= w_n;
      r_z     <= w_z;
      r_v     <= w_v;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign out_valid = r_valid;
  assign out_src   = r_src;
  assign out_tag   = r_tag;
  assign out_sum   = r_sum;
  assign out_n     = r_n;
  assign out_z     = r_z;
  assign out_v     = r_v;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for the arithmetic, hand sequences for arbitration corners.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int WIDTH = 16;
  localparam int TAGW  = 2;

  logic             clk;
  logic             rst_n;
  logic             req0, mode0, req1, mode1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [TAGW-1:0]  tag0, tag1;
  logic             gnt0, gnt1;
  logic             out_valid, out_ready, out_src;
  logic [TAGW-1:0]  out_tag;
  logic [WIDTH-1:0] out_sum;
  logic             out_n, out_z, out_v;

  int n_vec;
  int n_bad;

  adder_arbiter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .mode0     (mode0),
    .a0        (a0),
    .b0        (b0),
    .tag0      (tag0),
    .gnt0      (gnt0),
    .req1      (req1),
    .mode1     (mode1),
    .a1        (a1),
    .b1        (b1),
    .tag1      (tag1),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_tag   (out_tag),
    .out_sum   (out_sum),
    .out_n     (out_n),
    .out_z     (out_z),
    .out_v     (out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  tag;
    logic [15:0] e_sum;
    logic        e_n;
    logic        e_z;
    logic        e_v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic src, input logic mode, input logic [15:0] a,
                              input logic [15:0] b, input logic [1:0] tag, input logic [15:0] s,
                              input logic n, input logic z, input logic v);
    vec_t t;
    t.src = src; t.mode = mode; t.a = a; t.b = b; t.tag = tag;
    t.e_sum = s; t.e_n = n; t.e_z = z; t.e_v = v;
    return t;
  endfunction

  task automatic idle_reqs();
    req0 = 1'b0; mode0 = 1'b0; a0 = '0; b0 = '0; tag0 = '0;
    req1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0; tag1 = '0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    vecs[0] = mk(SRC_EX,  MODE_ADD, 16'h0003, 16'h0004, 2'd2, 16'h0007, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(SRC_AUX, MODE_ADD, 16'h7000, 16'h2000, 2'd1, SAT_POS,  1'b0, 1'b0, 1'b1);
    vecs[2] = mk(SRC_EX,  MODE_SUB, 16'h8000, 16'h0001, 2'd3, SAT_NEG,  1'b1, 1'b0, 1'b1);
    vecs[3] = mk(SRC_EX,  MODE_SUB, 16'h1234, 16'h1234, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[4] = mk(SRC_AUX, MODE_SUB, 16'h0005, 16'h0009, 2'd2, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    vecs[5] = mk(SRC_EX,  MODE_ADD, 16'h8000, 16'h8000, 2'd1, SAT_NEG,  1'b1, 1'b0, 1'b1);
    vecs[6] = mk(SRC_AUX, MODE_ADD, 16'hFFFF, 16'h0001, 2'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[7] = mk(SRC_EX,  MODE_SUB, 16'h7FFF, 16'hFFFF, 2'd0, SAT_POS,  1'b0, 1'b0, 1'b1);

    // Reset: outputs cleared, grants suppressed even with requests present.
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_reqs();
    #2;
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_out", {out_valid, out_src, out_tag, out_sum, out_n, out_z, out_v}, '0);
    idle_reqs();
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one requester at a time, grant same cycle, result one edge later.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_reqs();
      if (vecs[i].src == SRC_EX) begin
        req0 = 1'b1; mode0 = vecs[i].mode; a0 = vecs[i].a; b0 = vecs[i].b; tag0 = vecs[i].tag;
      end else begin
        req1 = 1'b1; mode1 = vecs[i].mode; a1 = vecs[i].a; b1 = vecs[i].b; tag1 = vecs[i].tag;
      end
      #1;
      chk($sformatf("v%0d_gnt", i), {gnt0, gnt1}, {vecs[i].src == SRC_EX, vecs[i].src == SRC_AUX});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", i), {out_valid, out_src, out_tag, out_sum},
          {1'b1, vecs[i].src, vecs[i].tag, vecs[i].e_sum});
      chk($sformatf("v%0d_flags", i), {out_n, out_z, out_v}, {vecs[i].e_n, vecs[i].e_z, vecs[i].e_v});
    end

    // Round robin from a fresh pointer: both held, expect 0,1,0,1.
    @(negedge clk);
    idle_reqs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 16'd1;  b0 = 16'd1;  tag0 = 2'd1;
    req1 = 1'b1; a1 = 16'd10; b1 = 16'd10; tag1 = 2'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_gnt", k), {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_out", k), {out_valid, out_src, out_sum},
          (k % 2 == 0) ? {1'b1, 1'b0, 16'd2} : {1'b1, 1'b1, 16'd20});
      @(negedge clk);
    end

    // Backpressure: full register with out_ready=0 freezes everything.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_gnt", k), {gnt0, gnt1}, 2'b00);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out", k), {out_valid, out_src, out_tag, out_sum}, {1'b1, 1'b1, 2'd2, 16'd20});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", {gnt0, gnt1}, 2'b10);
    @(posedge clk);
    #1;
    chk("bp_release_out", {out_valid, out_src, out_tag, out_sum}, {1'b1, 1'b0, 2'd1, 16'd2});

    // Drain with no grant: valid drops, data holds.
    @(negedge clk);
    idle_reqs();
    @(posedge clk);
    #1;
    chk("drain_out", {out_valid, out_src, out_sum}, {1'b0, 1'b0, 16'd2});

    // Load once more via requester 0 (pointer -> 1), stall, then async reset mid-cycle.
    @(negedge clk);
    req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0023; tag0 = 2'd3;
    @(posedge clk);
    #1;
    chk("pre_rst_out", {out_valid, out_sum}, {1'b1, 16'h0123});
    req0 = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {out_valid, out_tag, out_sum, out_v}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("post_rst_ptr", {gnt0, gnt1}, 2'b10);
    @(negedge clk);
    idle_reqs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Mutual exclusion of grants, sampled away from the clock edge.
  always @(negedge clk) begin
    if (gnt0 && gnt1) begin
      n_bad++;
      $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1, expected at most one");
    end
  end
endmodule
